// File: rtl/debug_host_link.sv
// rtl/debug_host_link.sv - host side of the debug UART link: sends commands and program words, collects pipeline dumps
// One transaction per accepted i_start; every output is a register driven from the single FSM block.
module debug_host_link #(
  parameter int DUMP_BYTES     = 320,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [1:0]  i_cmd,
  input  logic [7:0]  i_num_words,
  input  logic [31:0] i_word,
  output logic        o_word_req,
  output logic [7:0]  o_tx_data,
  output logic        os_tx_start,
  input  logic        is_tx_done,
  input  logic [7:0]  i_rx_data,
  input  logic        is_rx_done,
  output logic [7:0]  o_dump_data,
  output logic [8:0]  o_dump_idx,
  output logic        os_dump_valid,
  output logic        o_busy,
  output logic        os_done,
  output logic        o_timeout
);

  localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0]      CMD_LOAD  = 2'b01;
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]      DUMP_LAST = 9'(DUMP_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_CMD,
    S_WAIT_CMD,
    S_FETCH,
    S_SEND_BYTE,
    S_WAIT_BYTE,
    S_RECV,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [1:0]      r_cmd;
  logic [7:0]      r_num_words;
  logic [7:0]      r_word_cnt;
  logic [31:0]     r_shift;
  logic [1:0]      r_byte_cnt;
  logic [8:0]      r_dump_cnt;
  logic [TW-1:0]   r_tmo_cnt;

  logic            r_word_req;
  logic [7:0]      r_tx_data;
  logic            r_tx_start;
  logic [7:0]      r_dump_data;
  logic [8:0]      r_dump_idx;
  logic            r_dump_valid;
  logic            r_busy;
  logic            r_done;
  logic            r_timeout;

  assign o_word_req    = r_word_req;
  assign o_tx_data     = r_tx_data;
  assign os_tx_start   = r_tx_start;
  assign o_dump_data   = r_dump_data;
  assign o_dump_idx    = r_dump_idx;
  assign os_dump_valid = r_dump_valid;
  assign o_busy        = r_busy;
  assign os_done       = r_done;
  assign o_timeout     = r_timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cmd        <= 2'b00;
      r_num_words  <= 8'd0;
      r_word_cnt   <= 8'd0;
      r_shift      <= 32'd0;
      r_byte_cnt   <= 2'd0;
      r_dump_cnt   <= 9'd0;
      r_tmo_cnt    <= '0;
      r_word_req   <= 1'b0;
      r_tx_data    <= 8'h00;
      r_tx_start   <= 1'b0;
      r_dump_data  <= 8'h00;
      r_dump_idx   <= 9'd0;
      r_dump_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_word_req   <= 1'b0;
      r_tx_start   <= 1'b0;
      r_dump_valid <= 1'b0;
      r_done       <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (i_start && (i_cmd != 2'b00)) begin
            r_cmd       <= i_cmd;
            r_num_words <= i_num_words;
            r_word_cnt  <= 8'd0;
            r_timeout   <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_SEND_CMD;
          end
        end

        S_SEND_CMD: begin
          r_tx_data  <= {6'b0, r_cmd};
          r_tx_start <= 1'b1;
          r_state    <= S_WAIT_CMD;
        end

        S_WAIT_CMD: begin
          if (is_tx_done) begin
            if (r_cmd == CMD_LOAD) begin
              if (r_num_words != 8'd0) begin
                // Raised on entry so the request is high exactly during the capturing FETCH cycle.
                r_word_req <= 1'b1;
                r_state    <= S_FETCH;
              end else begin
                r_state <= S_DONE;
              end
            end else begin
              r_dump_cnt <= 9'd0;
              r_tmo_cnt  <= '0;
              r_state    <= S_RECV;
            end
          end
        end

        S_FETCH: begin
          r_shift    <= i_word;
          r_byte_cnt <= 2'd0;
          r_word_cnt <= r_word_cnt + 8'd1;
          r_state    <= S_SEND_BYTE;
        end

        S_SEND_BYTE: begin
          r_tx_data  <= r_shift[31:24];
          r_tx_start <= 1'b1;
          r_state    <= S_WAIT_BYTE;
        end

        S_WAIT_BYTE: begin
          if (is_tx_done) begin
            if (r_byte_cnt < 2'd3) begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
              r_shift    <= {r_shift[23:0], 8'h00};
              r_state    <= S_SEND_BYTE;
            end else if (r_word_cnt != r_num_words) begin
              r_word_req <= 1'b1;
              r_state    <= S_FETCH;
            end else begin
              r_state <= S_DONE;
            end
          end
        end

        S_RECV: begin
          // A byte arriving on the last allowed idle cycle still wins over the timeout.
          if (is_rx_done) begin
            r_dump_data  <= i_rx_data;
            r_dump_idx   <= r_dump_cnt;
            r_dump_valid <= 1'b1;
            r_dump_cnt   <= r_dump_cnt + 9'd1;
            r_tmo_cnt    <= '0;
            if (r_dump_cnt == DUMP_LAST) begin
              r_state <= S_DONE;
            end
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
          end
        end

        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_host_link.sv
// tb/tb_debug_host_link.sv - randomized self-checking bench for debug_host_link
// Reference model: expected byte streams and dump records built from the link protocol with plain queues.
module tb_debug_host_link;

  localparam int DUMP_BYTES = 320;
  localparam int TMO        = 50;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        i_start;
  logic [1:0]  i_cmd;
  logic [7:0]  i_num_words;
  logic [31:0] i_word = 32'h0;
  logic        o_word_req;
  logic [7:0]  o_tx_data;
  logic        os_tx_start;
  logic        is_tx_done;
  logic [7:0]  i_rx_data;
  logic        is_rx_done;
  logic [7:0]  o_dump_data;
  logic [8:0]  o_dump_idx;
  logic        os_dump_valid;
  logic        o_busy;
  logic        os_done;
  logic        o_timeout;

  logic        resp_done = 1'b0;
  logic        stray_tx;
  assign is_tx_done = resp_done | stray_tx;

  debug_host_link #(
    .DUMP_BYTES     (DUMP_BYTES),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_start       (i_start),
    .i_cmd         (i_cmd),
    .i_num_words   (i_num_words),
    .i_word        (i_word),
    .o_word_req    (o_word_req),
    .o_tx_data     (o_tx_data),
    .os_tx_start   (os_tx_start),
    .is_tx_done    (is_tx_done),
    .i_rx_data     (i_rx_data),
    .is_rx_done    (is_rx_done),
    .o_dump_data   (o_dump_data),
    .o_dump_idx    (o_dump_idx),
    .os_dump_valid (os_dump_valid),
    .o_busy        (o_busy),
    .os_done       (os_done),
    .o_timeout     (o_timeout)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0]  tx_log[$];
  logic [8:0]  dump_idx_q[$];
  logic [7:0]  dump_data_q[$];
  logic [31:0] word_q[$];
  int          word_base = 0;
  int          wreq_cnt = 0;
  int          done_cnt = 0;
  int          act_cnt = 0;
  int          tx_done_cnt = 0;
  int          overlap_cnt = 0;
  bit          tx_pending = 1'b0;
  int          tx_delay = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // UART transmitter stand-in plus passive monitor, all on the falling edge.
  always @(negedge clk) begin
    resp_done = 1'b0;
    if (!rst) begin
      tx_pending = 1'b0;
    end else begin
      if (os_tx_start) begin
        tx_log.push_back(o_tx_data);
        if (tx_pending) overlap_cnt++;
        tx_pending = 1'b1;
        tx_delay   = $urandom_range(1, 5);
      end else if (tx_pending) begin
        if (tx_delay == 0) begin
          resp_done   = 1'b1;
          tx_pending  = 1'b0;
          tx_done_cnt++;
        end else begin
          tx_delay--;
        end
      end
      if (o_word_req) begin
        if (wreq_cnt - word_base < word_q.size()) i_word = word_q[wreq_cnt - word_base];
        else i_word = 32'hDEAD_BEEF;
        wreq_cnt++;
      end
      if (os_dump_valid) begin
        dump_idx_q.push_back(o_dump_idx);
        dump_data_q.push_back(o_dump_data);
      end
      if (os_done) done_cnt++;
    end
    if (o_word_req || os_tx_start || os_dump_valid || os_done || o_busy) act_cnt++;
  end

  function automatic logic [63:0] all_outs();
    return 64'({o_word_req, os_tx_start, os_dump_valid, os_done, o_busy, o_timeout,
                o_tx_data, o_dump_data, o_dump_idx});
  endfunction

  task automatic start_txn(input logic [1:0] cmd, input logic [7:0] n);
    @(negedge clk);
    i_cmd       = cmd;
    i_num_words = n;
    i_start     = 1'b1;
    @(negedge clk);
    i_start     = 1'b0;
    i_cmd       = 2'b00;
  endtask

  task automatic wait_done(input int db0, input int budget);
    int k;
    k = 0;
    while (done_cnt == db0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", 64'(done_cnt > db0), 64'd1);
  endtask

  task automatic do_load(input int n, input logic [31:0] ws[$]);
    int tb0, db0, got_len;
    logic [7:0] exp[$];
    word_q    = ws;
    word_base = wreq_cnt;
    tb0       = tx_log.size();
    db0       = done_cnt;
    exp.push_back(8'h01);
    foreach (ws[i]) for (int b = 3; b >= 0; b--) exp.push_back(8'(ws[i] >> (8 * b)));
    start_txn(2'b01, 8'(n));
    wait_done(db0, 3000);
    repeat (3) @(negedge clk);
    got_len = tx_log.size() - tb0;
    check("load_len", 64'(got_len), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got_len; i++) check("load_byte", 64'(tx_log[tb0 + i]), 64'(exp[i]));
    check("load_wreq", 64'(wreq_cnt - word_base), 64'(n));
    check("load_done", 64'(done_cnt - db0), 64'd1);
    check("load_busy", 64'(o_busy), 64'd0);
  endtask

  task automatic do_recv(input logic [1:0] cmd, input int nbytes, input bit pat, input bit exp_tmo);
    int tb0, td0, db0, dv0, k, got_n;
    logic [7:0] exp[$];
    logic [7:0] d;
    tb0 = tx_log.size();
    td0 = tx_done_cnt;
    db0 = done_cnt;
    dv0 = dump_idx_q.size();
    start_txn(cmd, 8'($urandom));
    k = 0;
    while (tx_done_cnt == td0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("cmd_sent", 64'(tx_done_cnt > td0), 64'd1);
    check("cmd_len", 64'(tx_log.size() - tb0), 64'd1);
    if (tx_log.size() > tb0) check("cmd_byte", 64'(tx_log[tb0]), 64'({6'b0, cmd}));
    for (int i = 0; i < nbytes; i++) begin
      repeat ($urandom_range(1, 20)) @(negedge clk);
      d = pat ? 8'(i % 64) : 8'($urandom);
      exp.push_back(d);
      i_rx_data  = d;
      is_rx_done = 1'b1;
      @(negedge clk);
      is_rx_done = 1'b0;
    end
    if (exp_tmo) begin
      k = 1;
      while (!os_done && k < 4 * TMO) begin
        @(negedge clk);
        k++;
      end
      check("tmo_latency_ok", 64'(k >= TMO && k <= TMO + 3), 64'd1);
    end else begin
      wait_done(db0, 100);
    end
    repeat (3) @(negedge clk);
    got_n = dump_idx_q.size() - dv0;
    check("dump_count", 64'(got_n), 64'(nbytes));
    for (int i = 0; i < nbytes && i < got_n; i++) begin
      check("dump_idx", 64'(dump_idx_q[dv0 + i]), 64'(i));
      check("dump_data", 64'(dump_data_q[dv0 + i]), 64'(exp[i]));
    end
    check("recv_done", 64'(done_cnt - db0), 64'd1);
    check("timeout_flag", 64'(o_timeout), 64'(exp_tmo));
    if (exp_tmo) check("hold_idx", 64'(o_dump_idx), 64'(nbytes - 1));
    check("recv_busy", 64'(o_busy), 64'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, tb0, k, n;
    logic [31:0] wq[$];
    rst = 1'b0; i_start = 1'b0; i_cmd = 2'b00; i_num_words = 8'd0;
    i_rx_data = 8'h00; is_rx_done = 1'b0; stray_tx = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), 64'd0);
    rst = 1'b1;
    base = act_cnt;
    repeat (5) @(negedge clk);
    check("post_reset_quiet", 64'(act_cnt - base), 64'd0);

    base = act_cnt;
    i_rx_data = 8'h5A; is_rx_done = 1'b1; stray_tx = 1'b1;
    @(negedge clk);
    is_rx_done = 1'b0; stray_tx = 1'b0;
    i_start = 1'b1; i_cmd = 2'b00; i_num_words = 8'd3;
    @(negedge clk);
    i_start = 1'b0;
    repeat (5) @(negedge clk);
    check("stray_activity", 64'(act_cnt - base), 64'd0);
    check("stray_busy", 64'(o_busy), 64'd0);

    wq = '{32'h11223344, 32'hAABBCCDD};
    do_load(2, wq);
    wq = {};
    do_load(0, wq);
    for (int t = 0; t < 3; t++) begin
      n  = $urandom_range(1, 5);
      wq = {};
      for (int j = 0; j < n; j++) wq.push_back($urandom);
      do_load(n, wq);
    end

    do_recv(2'b10, DUMP_BYTES, 1'b1, 1'b0);
    do_recv(2'b11, DUMP_BYTES, 1'b0, 1'b0);
    do_recv(2'b11, 5, 1'b0, 1'b1);

    wq = '{32'h11223344, 32'hAABBCCDD};
    word_q    = wq;
    word_base = wreq_cnt;
    tb0       = tx_log.size();
    start_txn(2'b01, 8'd2);
    k = 0;
    while (tx_log.size() - tb0 < 4 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("reached_third_byte", 64'(tx_log.size() - tb0 >= 4), 64'd1);
    rst = 1'b0;
    #1;
    check("midreset_outs", all_outs(), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    base = act_cnt;
    repeat (5) @(negedge clk);
    check("post_midreset_quiet", 64'(act_cnt - base), 64'd0);
    wq = '{32'h01020304};
    do_load(1, wq);

    check("tx_overlap", 64'(overlap_cnt), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_host_link.md
DEBUG_HOST_LINK -- requirements
Module: debug_host_link

Interface
REQ-001 SHALL have parameter DUMP_BYTES, default 320, the number of bytes in one pipeline dump returned by the debug unit.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, the maximum idle cycles allowed between received dump bytes.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port i_start  input  1  start request for one transaction, sampled only in IDLE.
REQ-006 SHALL have port i_cmd  input  2  transaction code: 01 = load, 10 = run, 11 = step, 00 = ignored.
REQ-007 SHALL have port i_num_words  input  8  number of 32-bit instructions sent in a load.
REQ-008 SHALL have port i_word  input  32  next instruction word; it must be valid while o_word_req is high.
REQ-009 SHALL have port o_word_req  output  1  one-cycle pulse; i_word is captured in this cycle.
REQ-010 SHALL have port o_tx_data  output  8  byte to the UART transmitter.
REQ-011 SHALL have port os_tx_start  output  1  one-cycle pulse that starts transmission of o_tx_data.
REQ-012 SHALL have port is_tx_done  input  1  the transmitter has finished a byte.
REQ-013 SHALL have port i_rx_data  input  8  byte from the UART receiver.
REQ-014 SHALL have port is_rx_done  input  1  one-cycle pulse; i_rx_data is valid.
REQ-015 SHALL have port o_dump_data  output  8  captured dump byte.
REQ-016 SHALL have port o_dump_idx  output  9  index of the dump byte, 0-based.
REQ-017 SHALL have port os_dump_valid  output  1  one-cycle pulse; o_dump_data and o_dump_idx are valid.
REQ-018 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-019 SHALL have port os_done  output  1  one-cycle pulse at the end of a transaction.
REQ-020 SHALL have port o_timeout  output  1  sticky flag; the last dump was aborted by timeout.

Function
REQ-021 SHALL implement the states IDLE, SEND_CMD, WAIT_CMD, FETCH, SEND_BYTE, WAIT_BYTE, RECV and DONE.
REQ-022 IDLE: when i_start=1 and i_cmd!=00, SHALL latch i_cmd and i_num_words, clear o_timeout, and go to SEND_CMD; i_cmd=00 SHALL leave the block in IDLE.
REQ-023 SEND_CMD SHALL drive o_tx_data={6'b0,cmd}, pulse os_tx_start for one cycle, and go to WAIT_CMD.
REQ-024 WAIT_CMD: on is_tx_done, the next state SHALL be:
  - FETCH for a load with words>0;
  - DONE for a load with words=0;
  - RECV for run or step.
REQ-025 FETCH SHALL pulse o_word_req, latch i_word into the shift register, reset the byte counter to 0, and go to SEND_BYTE.
REQ-026 SHALL send the bytes of each word MSB first: [31:24], [23:16], [15:8], [7:0].
REQ-027 SEND_BYTE SHALL pulse os_tx_start with the current byte and go to WAIT_BYTE.
REQ-028 WAIT_BYTE: on is_tx_done, the next state SHALL be:
  - SEND_BYTE if the byte counter is less than 3;
  - FETCH if more words remain;
  - DONE otherwise.
REQ-029 os_tx_start SHALL never be reissued before the is_tx_done of the previous byte.
REQ-030 SHALL ignore is_tx_done outside WAIT_CMD and WAIT_BYTE.
REQ-031 RECV: on each is_rx_done, in the next cycle SHALL set o_dump_data=i_rx_data and o_dump_idx=count, pulse os_dump_valid, and increment count.
REQ-032 RECV: after byte index DUMP_BYTES-1 is captured, SHALL go to DONE.
REQ-033 SHALL ignore is_rx_done outside RECV; no os_dump_valid is produced there.
REQ-034 SHALL keep a timeout counter that is cleared on entry to RECV and on each is_rx_done, and increments otherwise.
REQ-035 When the timeout counter reaches TIMEOUT_CYCLES-1 with no byte received, SHALL set o_timeout=1 and go to DONE.
REQ-036 SHALL give is_rx_done priority over timeout in the same cycle.
REQ-037 DONE SHALL pulse os_done for one cycle and return to IDLE; o_busy SHALL fall in that same return cycle.
REQ-038 o_dump_data and o_dump_idx SHALL hold their last values until the next capture.
REQ-039 The word counter SHALL be 8 bits and the dump counter 9 bits; neither SHALL wrap within a transaction.

Reset
REQ-040 rst=0 SHALL at any time, including mid-transaction, immediately force IDLE and clear all counters.
REQ-041 rst=0 SHALL set these outputs to 0:
  - o_word_req, os_tx_start, os_dump_valid, os_done, o_busy, o_timeout;
  - o_tx_data=8'h00, o_dump_data=8'h00, o_dump_idx=0.
REQ-042 After reset release, no pulse output SHALL assert until a new i_start is accepted.

Verification
REQ-043 Load: i_cmd=01, i_num_words=2, words 0x11223344 and 0xAABBCCDD -> bytes 01,11,22,33,44,AA,BB,CC,DD; 2 o_word_req pulses; 1 os_done.
REQ-044 Load with zero words: i_cmd=01, i_num_words=0 -> only byte 01 is sent, then os_done; o_word_req never pulses.
REQ-045 Run: i_cmd=10 -> byte 02 is sent; 320 rx bytes 0x00..0x3F repeating -> 320 os_dump_valid pulses with idx 0..319 and matching data; os_done; o_timeout=0.
REQ-046 Timeout: i_cmd=11 with TIMEOUT_CYCLES=50, rx stops after 5 bytes -> os_done 50 cycles after the last byte; o_timeout=1; o_dump_idx=4.
REQ-047 Reset mid-load: assert rst=0 during the third data byte -> all outputs 0, IDLE; a later i_cmd=01 restarts with byte 01.
REQ-048 Stray inputs: is_rx_done or is_tx_done pulses in IDLE, and i_start with i_cmd=00 -> no output activity; o_busy stays 0.
